ov7670_pixel_capture: RTL and testbench
=======================================

Name: ov7670_pixel_capture

Overview:
- Captures the OV7670 parallel byte stream (RGB565, two bytes per pixel) in the camera's `pclk` domain.
- Converts each pixel to RGB444 and decimates VGA 640x480 by 2 in both axes to QVGA 320x240.
- Emits one write per kept pixel (`addr`, `pixel`, `we`) into a 76800-entry frame buffer downstream.

Parameters:
- H_ACTIVE, 640, active pixels per `href` line (1280 bytes).
- V_ACTIVE, 480, active lines per frame.
- ADDR_W, 17, frame-buffer address width; must hold (H_ACTIVE/2)*(V_ACTIVE/2)-1 = 76799.

Ports:
- pclk  in  1  camera pixel clock; only clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vsync  in  1  frame sync; high = vertical blanking.
- href  in  1  line valid; high = `d` carries an active byte.
- d  in  8  camera data byte.
- addr  out  ADDR_W  frame-buffer write address.
- pixel  out  12  RGB444 pixel, {R[3:0],G[3:0],B[3:0]}.
- we  out  1  one-cycle write strobe.

Behaviour:
- Reset: `addr`=0, `pixel`=0, `we`=0, byte phase=0, column counter=0, row counter=0, line-active flag=0.
- `d` and `href` are sampled on each rising `pclk`. A byte is accepted only when `href`=1 and `vsync`=0.
- Byte phase toggles on each accepted byte:
  - Phase 0 stores byte A = {R4..R0,G5..G3}.
  - Phase 1 (byte B = {G2..G0,B4..B0}) completes the pixel.
- RGB444 conversion: R = A[7:4]; G = {A[2:0],B[7]}; B = B[4:1].
- Column counter (0..H_ACTIVE-1) increments on each completed pixel.
- A pixel is kept only when column and row are both even.
- Kept pixel timing: `pixel` and `we`=1 are registered on the edge that samples byte B, so they are valid the cycle after. `addr` shows that pixel's address during the `we` cycle.
- `addr` increments by 1 in the cycle after each `we`. `we` is otherwise 0 and never high two consecutive cycles.
- Falling `href` (registered previous `href`=1, current=0): byte phase=0, column=0, row increments.
- A partial pixel (odd byte count) at line end is discarded.
- `vsync`=1 (level) for any cycle: byte phase, column, row and next address go to 0; `we` is forced 0.
- `pixel` keeps its last value when `we`=0.
- Overflow: once 76800 pixels have been written in a frame, further kept pixels are dropped (`we` stays 0) until `vsync`. `addr` never wraps past 76799.
- Extra bytes past H_ACTIVE on a line are ignored (column saturates); extra lines past V_ACTIVE are ignored.
- `rst` has priority over every other event. A mid-frame reset resumes capture only after the next `vsync` pulse.

Optional Feature:
- Macro `OV7670_CAP_FRAME_DONE_EN`.
- Defined:
  - Adds output `frame_done` (1 bit): one-cycle pulse on `vsync` rising edge, only if the just-ended frame wrote exactly 76800 pixels.
  - Adds output `frame_err` (1 bit): same pulse when the count differs.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour identical.

Decomposition:
- Package `ov7670_cap_pkg`:
  - Constants H_ACTIVE, V_ACTIVE, QVGA_W=320, QVGA_H=240, FRAME_PIXELS=76800.
  - Typedef `rgb444_t` (packed struct r/g/b, 4 bits each).
  - Typedef `rgb565_t`.
- One natural sub-module: `rgb565_to_rgb444`, purely combinational from the two captured bytes to `rgb444_t`.

Test Plan:
- Reset: assert `rst` 3 cycles with `href`=1 and random `d` -> `we`=0, `addr`=0, `pixel`=0 throughout.
- Single pixel: `vsync`=0, `href`=1 for bytes 0xF8,0x1F -> one `we` pulse, `pixel`=0xF0F, `addr`=0. Next kept pixel (bytes 5-6) -> `addr`=1.
- Full line: 1280 bytes of colour bars (0xF800=red, 0x07E0=green, 0x001F=blue segments) -> 320 `we` pulses, `addr` 0..319, values 0xF00/0x0F0/0x00F.
- Row decimation: second line of 1280 bytes -> zero `we` pulses. Third line -> `addr` starts at 320.
- Full frame: `vsync`=1 for 10 cycles, then 480 lines of 1280 bytes with 10-cycle gaps -> exactly 76800 `we`, last `addr`=76799. Following `vsync` -> next write at `addr`=0. With `OV7670_CAP_FRAME_DONE_EN`: one `frame_done` pulse.
- Overflow/odd bytes: 481 lines and a line of 1281 bytes -> no `we` beyond `addr` 76799; stray byte dropped; next line's first pixel correct.

Source files
------------

// File: rtl/ov7670_cap_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cap_pkg
// Shared constants and pixel types for the OV7670 capture path.
//   H_ACTIVE / V_ACTIVE : active VGA geometry delivered by the camera
//   QVGA_W / QVGA_H     : geometry after 2x2 decimation
//   FRAME_PIXELS        : frame-buffer entries written per frame
//   rgb444_t            : frame-buffer pixel {r,g,b}, 4 bits each
//   rgb565_t            : camera pixel, byte A then byte B concatenated
// ---------------------------------------------------------------------------
package ov7670_cap_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int QVGA_W       = H_ACTIVE / 2;
    localparam int QVGA_H       = V_ACTIVE / 2;
    localparam int FRAME_PIXELS = QVGA_W * QVGA_H;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/rgb565_to_rgb444.sv
// ---------------------------------------------------------------------------
// rgb565_to_rgb444
// Combinational conversion of one camera pixel (two bytes) to RGB444 by
// keeping the most significant four bits of each channel.
//   byte_a_i : first byte  {R4..R0,G5..G3}
//   byte_b_i : second byte {G2..G0,B4..B0}
//   rgb_o    : converted pixel
// ---------------------------------------------------------------------------
module rgb565_to_rgb444
    import ov7670_cap_pkg::*;
(
    input  logic [7:0] byte_a_i,
    input  logic [7:0] byte_b_i,
    output rgb444_t    rgb_o
);

    rgb565_t px;
    logic    unused_lsbs;

    always_comb begin
        px      = rgb565_t'({byte_a_i, byte_b_i});
        rgb_o.r = px.r[4:1];
        rgb_o.g = px.g[5:2];
        rgb_o.b = px.b[4:1];
    end

    // Truncated channel LSBs are intentionally dropped.
    assign unused_lsbs = ^{px.r[0], px.g[1:0], px.b[0]};

endmodule

// File: rtl/ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// ov7670_pixel_capture
// Captures the OV7670 RGB565 byte stream, converts to RGB444 and keeps every
// second pixel of every second line, producing one frame-buffer write per
// kept pixel. Everything runs on the camera pixel clock.
//   pclk       : camera pixel clock
//   rst        : synchronous active-high reset
//   vsync      : high during vertical blanking (clears all counters)
//   href       : high while d carries an active byte
//   d          : camera data byte
//   addr       : frame-buffer address, valid while we is high
//   pixel      : RGB444 pixel {R,G,B}, holds its value between writes
//   we         : single-cycle write strobe
// Optional (macro OV7670_CAP_FRAME_DONE_EN):
//   frame_done : pulse at vsync rise when the finished frame was complete
//   frame_err  : pulse at vsync rise when it was not
// ---------------------------------------------------------------------------
module ov7670_pixel_capture #(
    parameter int H_ACTIVE = ov7670_cap_pkg::H_ACTIVE,
    parameter int V_ACTIVE = ov7670_cap_pkg::V_ACTIVE,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       pixel,
    output logic              we
`ifdef OV7670_CAP_FRAME_DONE_EN
    ,
    output logic              frame_done,
    output logic              frame_err
`endif
);
    import ov7670_cap_pkg::*;

    localparam int FRAME_PIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
    localparam int COL_W     = $clog2(H_ACTIVE + 1);
    localparam int ROW_W     = $clog2(V_ACTIVE + 1);
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    // Column/row counters get one extra "past the end" value at which they
    // saturate, so trailing bytes and lines fall out of the keep test.
    localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIX - 1);

    logic              phase_q,  phase_d;
    logic [7:0]        byte_a_q, byte_a_d;
    logic [COL_W-1:0]  col_q,    col_d;
    logic [ROW_W-1:0]  row_q,    row_d;
    logic              href_q,   href_d;
    logic              armed_q,  armed_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [11:0]       pixel_q,  pixel_d;
    logic              we_q,     we_d;
`ifdef OV7670_CAP_FRAME_DONE_EN
    logic              vsync_q,  vsync_d;
    logic              done_q,   done_d;
    logic              err_q,    err_d;
`endif

    rgb444_t conv;
    logic    accept;
    logic    line_end;
    logic    keep;

    rgb565_to_rgb444 u_conv (
        .byte_a_i (byte_a_q),
        .byte_b_i (d),
        .rgb_o    (conv)
    );

    always_comb begin
        phase_d  = phase_q;
        byte_a_d = byte_a_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        wr_cnt_d = wr_cnt_q;
        pixel_d  = pixel_q;
        we_d     = 1'b0;
        href_d   = href;
        // After reset, capture waits for a vsync so it starts on a frame edge.
        armed_d  = armed_q | vsync;

        accept   = href && !vsync && armed_q;
        line_end = href_q && !href;
        // wr_cnt_q is already up to date here: a write strobe can never be
        // pending on the edge that samples byte B.
        keep     = (col_q < COL_END) && (row_q < ROW_END) &&
                   !col_q[0] && !row_q[0] && (wr_cnt_q < CNT_FULL);

        // Advance past the address just written; saturate on the last entry.
        if (we_q) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (addr_q != ADDR_LAST) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (vsync) begin
            phase_d  = 1'b0;
            col_d    = '0;
            row_d    = '0;
            addr_d   = '0;
            wr_cnt_d = '0;
        end else if (line_end) begin
            // Dropping the phase discards any half pixel left on the line.
            phase_d = 1'b0;
            col_d   = '0;
            if (row_q != ROW_END) begin
                row_d = row_q + ROW_W'(1);
            end
        end else if (accept) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                byte_a_d = d;
            end else begin
                if (col_q != COL_END) begin
                    col_d = col_q + COL_W'(1);
                end
                if (keep) begin
                    we_d    = 1'b1;
                    pixel_d = conv;
                end
            end
        end
    end

`ifdef OV7670_CAP_FRAME_DONE_EN
    always_comb begin
        vsync_d = vsync;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (vsync && !vsync_q) begin
            // Include a write whose strobe is still visible this cycle.
            if ((wr_cnt_q + CNT_W'(we_q)) == CNT_FULL) begin
                done_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign frame_done = done_q;
    assign frame_err  = err_q;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q  <= 1'b0;
            byte_a_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            href_q   <= 1'b0;
            armed_q  <= 1'b0;
            addr_q   <= '0;
            wr_cnt_q <= '0;
            pixel_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            byte_a_q <= byte_a_d;
            col_q    <= col_d;
            row_q    <= row_d;
            href_q   <= href_d;
            armed_q  <= armed_d;
            addr_q   <= addr_d;
            wr_cnt_q <= wr_cnt_d;
            pixel_q  <= pixel_d;
            we_q     <= we_d;
        end
    end

    assign addr  = addr_q;
    assign pixel = pixel_q;
    assign we    = we_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// tb_ov7670_pixel_capture
// Two instances share one camera stream: u_big at full VGA geometry and
// u_small at 32x12 so whole frames fit in a short run. A reference model
// derives every expected write from line/pixel indices and a per-frame
// write count; monitors pop the expected queues on each write strobe.
// ---------------------------------------------------------------------------
module tb_ov7670_pixel_capture;

    localparam int BH = 640;
    localparam int BV = 480;
    localparam int BA = 17;
    localparam int SH = 32;
    localparam int SV = 12;
    localparam int SA = 7;
    localparam int BFRAME = (BH / 2) * (BV / 2);
    localparam int SFRAME = (SH / 2) * (SV / 2);

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic rst;
    logic vsync;
    logic href;
    logic [7:0] d;

    always #5 pclk = ~pclk;

    logic [BA-1:0] b_addr;
    logic [11:0]   b_pixel;
    logic          b_we;
    logic [SA-1:0] s_addr;
    logic [11:0]   s_pixel;
    logic          s_we;
`ifdef OV7670_CAP_FRAME_DONE_EN
    logic b_done, b_err, s_done, s_err;
`endif

    ov7670_pixel_capture #(.H_ACTIVE(BH), .V_ACTIVE(BV), .ADDR_W(BA)) u_big (
        .pclk  (pclk),
        .rst   (rst),
        .vsync (vsync),
        .href  (href),
        .d     (d),
        .addr  (b_addr),
        .pixel (b_pixel),
        .we    (b_we)
`ifdef OV7670_CAP_FRAME_DONE_EN
        ,
        .frame_done (b_done),
        .frame_err  (b_err)
`endif
    );

    ov7670_pixel_capture #(.H_ACTIVE(SH), .V_ACTIVE(SV), .ADDR_W(SA)) u_small (
        .pclk  (pclk),
        .rst   (rst),
        .vsync (vsync),
        .href  (href),
        .d     (d),
        .addr  (s_addr),
        .pixel (s_pixel),
        .we    (s_we)
`ifdef OV7670_CAP_FRAME_DONE_EN
        ,
        .frame_done (s_done),
        .frame_err  (s_err)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    // Entry = {addr[16:0], pixel[11:0]}
    logic [28:0] b_exp_q[$];
    logic [28:0] s_exp_q[$];

    int m_line[2];
    int m_wr[2];
    bit m_armed;
    logic [7:0] line_bytes[$];

    int b_seen = 0;
    int s_seen = 0;
    logic [11:0] b_last_pix = 12'h000;
    logic [11:0] s_last_pix = 12'h000;
    logic b_prev_we = 1'b0;
    logic s_prev_we = 1'b0;

    int exp_done[2];
    int exp_err[2];
    int b_done_seen = 0;
    int b_err_seen  = 0;
    int s_done_seen = 0;
    int s_err_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RGB565 bytes -> RGB444 by channel arithmetic.
    function automatic logic [11:0] to444(input logic [7:0] a, input logic [7:0] b);
        int r;
        int g;
        int bl;
        r  = int'(a) / 16;
        g  = (int'(a) % 8) * 2 + int'(b) / 128;
        bl = (int'(b) / 2) % 16;
        return 12'(r * 256 + g * 16 + bl);
    endfunction

    // Expected writes for the line held in line_bytes, for geometry g.
    task automatic model_line(input int g);
        int h;
        int v;
        int frame;
        logic [28:0] e;
        h     = (g == 0) ? BH : SH;
        v     = (g == 0) ? BV : SV;
        frame = (h / 2) * (v / 2);
        for (int p = 0; 2 * p + 1 < line_bytes.size(); p++) begin
            if (m_armed && p < h && m_line[g] < v && (p % 2) == 0 &&
                (m_line[g] % 2) == 0 && m_wr[g] < frame) begin
                e = {17'(m_wr[g]), to444(line_bytes[2 * p], line_bytes[2 * p + 1])};
                if (g == 0) b_exp_q.push_back(e);
                else        s_exp_q.push_back(e);
                m_wr[g]++;
            end
        end
        m_line[g]++;
    endtask

    // ---------------- driver tasks ----------------
    // mode 0: random bytes, 1: red/green/blue bars, 2: 0xF8,0x1F then random
    task automatic drive_line(input int n_bytes, input int mode);
        logic [7:0]  v;
        logic [15:0] w;
        int seg;
        line_bytes.delete();
        for (int i = 0; i < n_bytes; i++) begin
            v = 8'($urandom);
            if (mode == 1) begin
                seg = ((i / 2) * 3) / BH;
                w = (seg == 0) ? 16'hF800 : (seg == 1) ? 16'h07E0 : 16'h001F;
                v = ((i % 2) == 0) ? w[15:8] : w[7:0];
            end else if (mode == 2 && i == 0) begin
                v = 8'hF8;
            end else if (mode == 2 && i == 1) begin
                v = 8'h1F;
            end
            line_bytes.push_back(v);
        end
        model_line(0);
        model_line(1);
        for (int i = 0; i < n_bytes; i++) begin
            @(negedge pclk);
            href = 1'b1;
            d    = line_bytes[i];
        end
        @(negedge pclk);
        href = 1'b0;
        d    = 8'($urandom);
        repeat (10) @(negedge pclk);
    endtask

    task automatic pulse_vsync();
        if (m_wr[0] == BFRAME) exp_done[0]++; else exp_err[0]++;
        if (m_wr[1] == SFRAME) exp_done[1]++; else exp_err[1]++;
        m_line[0] = 0;
        m_line[1] = 0;
        m_wr[0]   = 0;
        m_wr[1]   = 0;
        m_armed   = 1'b1;
        @(negedge pclk);
        vsync = 1'b1;
        repeat (10) @(negedge pclk);
        vsync = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    // ---------------- monitors ----------------
    always @(negedge pclk) begin
        if (!rst) begin
            if (b_we !== 1'b0) begin
                logic [28:0] e;
                check_eq("big_we_back_to_back", 32'(b_prev_we), 32'd0);
                check_eq("big_we_expected", 32'(b_exp_q.size() != 0), 32'd1);
                if (b_exp_q.size() != 0) begin
                    e = b_exp_q.pop_front();
                    check_eq("big_addr", 32'(b_addr), 32'(e[28:12]));
                    check_eq("big_pixel", 32'(b_pixel), 32'(e[11:0]));
                    b_last_pix = e[11:0];
                end
                b_seen++;
            end else begin
                check_eq("big_pixel_hold", 32'(b_pixel), 32'(b_last_pix));
            end
            b_prev_we = b_we;
        end
    end

    always @(negedge pclk) begin
        if (!rst) begin
            if (s_we !== 1'b0) begin
                logic [28:0] e;
                check_eq("small_we_back_to_back", 32'(s_prev_we), 32'd0);
                check_eq("small_we_expected", 32'(s_exp_q.size() != 0), 32'd1);
                if (s_exp_q.size() != 0) begin
                    e = s_exp_q.pop_front();
                    check_eq("small_addr", 32'(s_addr), 32'(e[28:12]));
                    check_eq("small_pixel", 32'(s_pixel), 32'(e[11:0]));
                    s_last_pix = e[11:0];
                end
                s_seen++;
            end else begin
                check_eq("small_pixel_hold", 32'(s_pixel), 32'(s_last_pix));
            end
            s_prev_we = s_we;
        end
    end

`ifdef OV7670_CAP_FRAME_DONE_EN
    always @(negedge pclk) begin
        if (b_done === 1'b1) b_done_seen++;
        if (b_err  === 1'b1) b_err_seen++;
        if (s_done === 1'b1) s_done_seen++;
        if (s_err  === 1'b1) s_err_seen++;
    end
`endif

    // ---------------- directed sequence ----------------
    initial begin
        int b0;
        int s0;
        rst      = 1'b1;
        vsync    = 1'b0;
        href     = 1'b1;
        d        = 8'($urandom);
        m_armed  = 1'b0;
        m_line   = '{0, 0};
        m_wr     = '{0, 0};
        exp_done = '{0, 0};
        exp_err  = '{0, 0};

        // Reset held with href active and random data.
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            d = 8'($urandom);
            check_eq("reset_big_we",      32'(b_we),    32'd0);
            check_eq("reset_big_addr",    32'(b_addr),  32'd0);
            check_eq("reset_big_pixel",   32'(b_pixel), 32'd0);
            check_eq("reset_small_we",    32'(s_we),    32'd0);
            check_eq("reset_small_addr",  32'(s_addr),  32'd0);
            check_eq("reset_small_pixel", 32'(s_pixel), 32'd0);
        end
        @(negedge pclk);
        rst  = 1'b0;
        href = 1'b0;
        repeat (2) @(negedge pclk);

        // No capture before the first vsync after reset.
        drive_line(64, 0);
        check_eq("unarmed_big_writes",   32'(b_seen), 32'd0);
        check_eq("unarmed_small_writes", 32'(s_seen), 32'd0);

        // Single pixel 0xF81F, then the next kept pixel (bytes 5-6).
        pulse_vsync();
        b0 = b_seen; s0 = s_seen;
        drive_line(6, 2);
        check_eq("single_big_writes",   32'(b_seen - b0), 32'd2);
        check_eq("single_small_writes", 32'(s_seen - s0), 32'd2);
        check_eq("single_big_addr_after", 32'(b_addr), 32'd2);

        // Full colour-bar line, then a decimated line, then line 2.
        pulse_vsync();
        b0 = b_seen; s0 = s_seen;
        drive_line(1280, 1);
        check_eq("line0_big_writes",   32'(b_seen - b0), 32'd320);
        check_eq("line0_small_writes", 32'(s_seen - s0), 32'd16);
        b0 = b_seen; s0 = s_seen;
        drive_line(1280, 0);
        check_eq("line1_big_writes",   32'(b_seen - b0), 32'd0);
        check_eq("line1_small_writes", 32'(s_seen - s0), 32'd0);
        b0 = b_seen; s0 = s_seen;
        drive_line(1280, 0);
        check_eq("line2_big_writes",   32'(b_seen - b0), 32'd320);
        check_eq("line2_small_writes", 32'(s_seen - s0), 32'd16);
        check_eq("line2_big_next_addr",   32'(b_addr), 32'd640);
        check_eq("line2_small_next_addr", 32'(s_addr), 32'd32);

        // Complete small frame: exactly SFRAME writes, address saturates.
        pulse_vsync();
        check_eq("vsync_big_addr_clear",   32'(b_addr), 32'd0);
        check_eq("vsync_small_addr_clear", 32'(s_addr), 32'd0);
        b0 = b_seen; s0 = s_seen;
        for (int l = 0; l < SV; l++) drive_line(64, 0);
        check_eq("frame_small_writes", 32'(s_seen - s0), 32'(SFRAME));
        check_eq("frame_big_writes",   32'(b_seen - b0), 32'd96);
        check_eq("frame_small_last_addr", 32'(s_addr), 32'(SFRAME - 1));

        // Odd-length first line, extra lines past the frame height.
        pulse_vsync();
        check_eq("vsync2_small_addr_clear", 32'(s_addr), 32'd0);
        b0 = b_seen; s0 = s_seen;
        drive_line(1281, 1);
        for (int l = 1; l <= SV + 1; l++) drive_line(64, 0);
        check_eq("overflow_small_writes", 32'(s_seen - s0), 32'(SFRAME));
        check_eq("overflow_big_writes",   32'(b_seen - b0), 32'd416);
        check_eq("overflow_small_addr",   32'(s_addr), 32'(SFRAME - 1));
        check_eq("overflow_big_addr",     32'(b_addr), 32'd416);

        pulse_vsync();
        check_eq("final_big_queue_drained",   32'(b_exp_q.size()), 32'd0);
        check_eq("final_small_queue_drained", 32'(s_exp_q.size()), 32'd0);
`ifdef OV7670_CAP_FRAME_DONE_EN
        check_eq("big_frame_done_count",   32'(b_done_seen), 32'(exp_done[0]));
        check_eq("big_frame_err_count",    32'(b_err_seen),  32'(exp_err[0]));
        check_eq("small_frame_done_count", 32'(s_done_seen), 32'(exp_done[1]));
        check_eq("small_frame_err_count",  32'(s_err_seen),  32'(exp_err[1]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
